// File: rtl/pipeline_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front end: default widths,
// reset PC, the canonical NOP encoding and the fetch FSM state constants.
package pipeline_fetch_unit_pkg;

  localparam int          ADDR_W_DEF   = 32;
  localparam int          DEPTH_DEF    = 2;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  localparam int                 INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP     = 32'h0000_0013;

  // Fetch FSM state encoding. Kept as plain constants so existing tools that
  // decode the debug state bus keep working.
  typedef logic [1:0] fetch_state_t;
  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/pipeline_fetch_unit_fetch_fifo.sv
// Generic synchronous FIFO with occupancy count and a synchronous flush.
// Flush and reset both empty the queue; flush wins over a same-cycle push or
// pop. A push while full is only taken when a pop frees a slot that cycle.
// dout shows the head entry and is meaningless while empty.
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage array: written on every accepted push, never reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/pipeline_fetch_unit.sv
// Instruction fetch front end. Owns the PC, issues in-order word fetches to
// instruction memory, tags each request with its PC and buffers the returned
// words for the decoder. Jump redirects flush the buffer and squash any
// fetches still in flight by counting their responses down in drop_cnt.
//
// Handshakes:
//   imem_req/imem_ready : a request transfers on a cycle where both are 1;
//                         imem_addr is stable whenever imem_req is 1.
//   imem_rvalid         : one response per accepted request, in order, no
//                         backpressure from this block.
//   out_valid/decoded_latch_en : the head entry transfers to the decoder on a
//                         cycle where both are 1 (and no redirect is present).
module pipeline_fetch_unit
  import pipeline_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter int                DEPTH    = DEPTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetch_en,
  input  logic                decoded_latch_en,
  input  logic                jmp_valid,
  input  logic [ADDR_W-1:0]   jmp_target,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_ready,
  input  logic                imem_rvalid,
  input  logic [INSTR_W-1:0]  imem_rdata,
  output logic                out_valid,
  output logic [INSTR_W-1:0]  out_instr,
  output logic [ADDR_W-1:0]   out_pc,
  output logic [1:0]          dbg_state
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]                state;
  logic [1:0]                state_nxt;
  logic [ADDR_W-1:0]         pc;
  logic [CW-1:0]             drop_cnt;
  logic [CW-1:0]             drop_nxt;

  // The tag queue occupancy is exactly the number of outstanding requests.
  logic [CW-1:0]             outstanding;
  logic                      tag_full;
  logic                      tag_empty;
  logic [ADDR_W-1:0]         tag_head;

  logic [CW-1:0]             buf_count;
  logic                      buf_full;
  logic                      buf_empty;
  logic [ADDR_W+INSTR_W-1:0] buf_head;

  logic [CW:0]               in_use;
  logic                      credit_ok;
  logic                      accept;
  logic                      rsp_take;
  logic                      rsp_keep;
  logic                      out_pop;

  // Every slot is either an outstanding request or a buffered word, so a new
  // request is only issued while their sum is below DEPTH; the buffer can
  // therefore never overflow when responses come back.
  assign in_use    = {1'b0, outstanding} + {1'b0, buf_count};
  assign credit_ok = (in_use < (CW+1)'(DEPTH)) & ~tag_full & ~buf_full;

  assign imem_req  = ~rst & (state != ST_BOOT) & fetch_en & ~jmp_valid & credit_ok;
  assign imem_addr = pc;
  assign accept    = imem_req & imem_ready;

  // A response with nothing outstanding (e.g. a stale one after reset) is
  // ignored so the counters cannot underflow.
  assign rsp_take  = ~rst & imem_rvalid & ~tag_empty;
  assign rsp_keep  = rsp_take & (drop_cnt == '0) & ~jmp_valid;

  assign out_valid = ~rst & ~buf_empty;
  assign out_pop   = out_valid & decoded_latch_en & ~jmp_valid;
  assign out_instr = out_valid ? buf_head[INSTR_W-1:0] : '0;
  assign out_pc    = out_valid ? buf_head[ADDR_W+INSTR_W-1:INSTR_W] : '0;

  assign dbg_state = state;

  fetch_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (DEPTH)
  ) u_tag_q (
    .clk   (clk),
    .rst   (rst),
    .flush (1'b0),
    .push  (accept),
    .din   (pc),
    .pop   (rsp_take),
    .dout  (tag_head),
    .count (outstanding),
    .full  (tag_full),
    .empty (tag_empty)
  );

  fetch_fifo #(
    .WIDTH (ADDR_W + INSTR_W),
    .DEPTH (DEPTH)
  ) u_instr_buf (
    .clk   (clk),
    .rst   (rst),
    .flush (jmp_valid),
    .push  (rsp_keep),
    .din   ({tag_head, imem_rdata}),
    .pop   (out_pop),
    .dout  (buf_head),
    .count (buf_count),
    .full  (buf_full),
    .empty (buf_empty)
  );

  // Squash bookkeeping: a redirect squashes everything outstanding, minus a
  // response that is discarded in the redirect cycle itself.
  always_comb begin
    drop_nxt = drop_cnt;
    if (jmp_valid) begin
      drop_nxt = outstanding - CW'(rsp_take);
    end else if (rsp_take && (drop_cnt != '0)) begin
      drop_nxt = drop_cnt - CW'(1);
    end
  end

  // Fetch FSM next state: BOOT idles one cycle, DRAIN while squashed
  // responses are still due.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_BOOT:  state_nxt = ST_RUN;
      ST_RUN:   if (jmp_valid && (drop_nxt != '0)) state_nxt = ST_DRAIN;
      ST_DRAIN: if (drop_nxt == '0) state_nxt = ST_RUN;
      default:  state_nxt = ST_BOOT;
    endcase
  end

  // State, squash counter and PC registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_BOOT;
      drop_cnt <= '0;
      pc       <= RESET_PC;
    end else begin
      state    <= state_nxt;
      drop_cnt <= drop_nxt;
      if (jmp_valid) begin
        pc <= jmp_target & ~ADDR_W'(3);
      end else if (accept) begin
        pc <= pc + ADDR_W'(4);
      end
    end
  end

endmodule
